// File: rtl/crc_ctrl_pkg.sv
// Shared types and constants for the serial CRC engine sequencer.
// Provides the controller state encoding, the default byte width and a
// helper that sizes counters from their terminal count.
package crc_ctrl_pkg;

  localparam int unsigned DEFAULT_DATA_WIDTH = 8;

  // Width of a counter that must hold values 0..n-1 (never narrower than 1).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 32'd1 : 32'($clog2(n));
  endfunction

  localparam int unsigned DEFAULT_BIT_CNT_W = cnt_w(DEFAULT_DATA_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    ENG_RST,
    SHIFT,
    DRAIN,
    WAIT_VALID,
    COLLECT,
    OUTPUT
  } state_t;

endpackage

// File: rtl/crc_bit_serializer.sv
// Byte-to-bit serializer feeding the CRC engine.
// Ports: clk, rst (sync, active-high); load (first byte of a frame),
// shift_en (controller is shifting), accept (byte handshake this cycle),
// in_data/in_last (byte and its last flag).
// Combinational outputs: sr_lsb_n_c (engine bit for next cycle),
// room_n_c (holding slot free and last not yet taken, next cycle),
// done_c (last byte's final bit now), underrun_c (no next byte at boundary).
module crc_bit_serializer
  import crc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic                  accept,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  sr_lsb_n_c,
  output logic                  room_n_c,
  output logic                  done_c,
  output logic                  underrun_c
);

  localparam int unsigned BIT_W = cnt_w(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] sr, sr_n, hold, hold_n;
  logic [BIT_W-1:0]      cnt, cnt_n;
  logic                  cur_last, cur_last_n;
  logic                  hold_full, hold_full_n;
  logic                  hold_last, hold_last_n;
  logic                  last_acc, last_acc_n;
  logic                  boundary;

  assign boundary   = shift_en && (cnt == BIT_W'(DATA_WIDTH - 1));
  assign done_c     = boundary && cur_last;
  assign underrun_c = boundary && !cur_last && !hold_full && !accept;
  assign sr_lsb_n_c = sr_n[0];
  assign room_n_c   = !hold_full_n && !last_acc_n;

  // Next-state for shift/holding registers; boundary swaps in the next byte with no gap.
  always_comb begin
    sr_n        = sr;
    hold_n      = hold;
    cnt_n       = cnt;
    cur_last_n  = cur_last;
    hold_full_n = hold_full;
    hold_last_n = hold_last;
    last_acc_n  = last_acc;
    if (load) begin
      sr_n        = in_data;
      cur_last_n  = in_last;
      last_acc_n  = in_last;
      hold_full_n = 1'b0;
      cnt_n       = '0;
    end else if (shift_en) begin
      if (!boundary) begin
        sr_n  = sr >> 1;
        cnt_n = cnt + BIT_W'(1);
        if (accept) begin
          hold_n      = in_data;
          hold_full_n = 1'b1;
          hold_last_n = in_last;
          last_acc_n  = last_acc | in_last;
        end
      end else begin
        cnt_n = '0;
        if (!cur_last) begin
          if (hold_full) begin
            sr_n        = hold;
            cur_last_n  = hold_last;
            hold_full_n = 1'b0;
          end else if (accept) begin
            sr_n       = in_data;
            cur_last_n = in_last;
            last_acc_n = last_acc | in_last;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr        <= '0;
      hold      <= '0;
      cnt       <= '0;
      cur_last  <= 1'b0;
      hold_full <= 1'b0;
      hold_last <= 1'b0;
      last_acc  <= 1'b0;
    end else begin
      sr        <= sr_n;
      hold      <= hold_n;
      cnt       <= cnt_n;
      cur_last  <= cur_last_n;
      hold_full <= hold_full_n;
      hold_last <= hold_last_n;
      last_acc  <= last_acc_n;
    end
  end

endmodule

// File: rtl/crc_serial_ctrl.sv
// Sequencer driving a bit-serial CRC engine from a byte stream.
// Ports: clk, rst (sync, active-high); in_data/in_valid/in_last/in_ready
// byte input; crc_rst_n/crc_active/crc_data to the engine, crc_bit/crc_valid
// from it; out_crc/out_valid/out_ready result; err (underrun or timeout
// pulse); busy (not idle). All outputs are registered.
module crc_serial_ctrl
  import crc_ctrl_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int unsigned RST_CYCLES     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  crc_rst_n,
  output logic                  crc_active,
  output logic                  crc_data,
  input  logic                  crc_bit,
  input  logic                  crc_valid,
  output logic [DATA_WIDTH-1:0] out_crc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  err,
  output logic                  busy
);

  localparam int unsigned BIT_W = cnt_w(DATA_WIDTH);
  localparam int unsigned RST_W = cnt_w(RST_CYCLES);
  localparam int unsigned TO_W  = cnt_w(TIMEOUT_CYCLES);

  state_t                state, state_n;
  logic [RST_W-1:0]      rst_cnt, rst_cnt_n;
  logic [TO_W-1:0]       to_cnt, to_cnt_n;
  logic [BIT_W-1:0]      col_cnt, col_cnt_n;
  logic [DATA_WIDTH-1:0] col, col_n, out_crc_n;
  logic                  in_ready_n, crc_rst_n_n, crc_active_n, crc_data_n;
  logic                  out_valid_n, err_n, busy_n;
  logic                  accept_c, load_c, shift_c;
  logic                  sr_lsb_n_c, room_n_c, done_c, underrun_c;

  assign accept_c = in_valid && in_ready;
  assign load_c   = (state == IDLE) && accept_c;
  assign shift_c  = (state == SHIFT);

  crc_bit_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .clk        (clk),
    .rst        (rst),
    .load       (load_c),
    .shift_en   (shift_c),
    .accept     (accept_c),
    .in_data    (in_data),
    .in_last    (in_last),
    .sr_lsb_n_c (sr_lsb_n_c),
    .room_n_c   (room_n_c),
    .done_c     (done_c),
    .underrun_c (underrun_c)
  );

  // Next state, counters, collector and next values of the registered outputs.
  always_comb begin
    state_n   = state;
    rst_cnt_n = rst_cnt;
    to_cnt_n  = to_cnt;
    col_cnt_n = col_cnt;
    col_n     = col;
    out_crc_n = out_crc;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (accept_c) begin
          rst_cnt_n = '0;
          state_n   = ENG_RST;
        end
      end
      ENG_RST: begin
        if (rst_cnt == RST_W'(RST_CYCLES - 1)) state_n = SHIFT;
        else rst_cnt_n = rst_cnt + RST_W'(1);
      end
      SHIFT: begin
        if (done_c) begin
          to_cnt_n = '0;
          state_n  = WAIT_VALID;
        end else if (underrun_c) begin
          err_n   = 1'b1;
          state_n = DRAIN;
        end
      end
      DRAIN: begin
        if (accept_c && in_last) state_n = IDLE;
      end
      WAIT_VALID: begin
        // A valid arriving on the timeout cycle still wins.
        if (crc_valid) begin
          col_cnt_n = '0;
          state_n   = COLLECT;
        end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end else begin
          to_cnt_n = to_cnt + TO_W'(1);
        end
      end
      COLLECT: begin
        col_n[col_cnt] = crc_bit;
        if (col_cnt == BIT_W'(DATA_WIDTH - 1)) begin
          out_crc_n = col_n;
          state_n   = OUTPUT;
        end else begin
          col_cnt_n = col_cnt + BIT_W'(1);
        end
      end
      OUTPUT: begin
        if (out_valid && out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // Outputs are decoded from the state being entered so they line up with it.
    in_ready_n   = (state_n == IDLE) || (state_n == DRAIN) ||
                   ((state_n == SHIFT) && room_n_c);
    crc_rst_n_n  = (state_n != ENG_RST);
    crc_active_n = (state_n == SHIFT);
    crc_data_n   = (state_n == SHIFT) && sr_lsb_n_c;
    out_valid_n  = (state_n == OUTPUT);
    busy_n       = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      rst_cnt    <= '0;
      to_cnt     <= '0;
      col_cnt    <= '0;
      col        <= '0;
      out_crc    <= '0;
      in_ready   <= 1'b0;
      crc_rst_n  <= 1'b0;
      crc_active <= 1'b0;
      crc_data   <= 1'b0;
      out_valid  <= 1'b0;
      err        <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      rst_cnt    <= rst_cnt_n;
      to_cnt     <= to_cnt_n;
      col_cnt    <= col_cnt_n;
      col        <= col_n;
      out_crc    <= out_crc_n;
      in_ready   <= in_ready_n;
      crc_rst_n  <= crc_rst_n_n;
      crc_active <= crc_active_n;
      crc_data   <= crc_data_n;
      out_valid  <= out_valid_n;
      err        <= err_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_crc_serial_ctrl.sv
// Self-checking bench for crc_serial_ctrl with a behavioural CRC engine.
// Expected engine bits and CRC results are queued as bytes are sent and
// compared when the DUT drives the engine / presents its result.
module tb_crc_serial_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       crc_rst_n, crc_active, crc_data;
  logic       crc_bit, crc_valid;
  logic [7:0] out_crc;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       err, busy;

  always #5 clk = ~clk;

  crc_serial_ctrl #(.DATA_WIDTH(8), .RST_CYCLES(1), .TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_last    (in_last),
    .in_ready   (in_ready),
    .crc_rst_n  (crc_rst_n),
    .crc_active (crc_active),
    .crc_data   (crc_data),
    .crc_bit    (crc_bit),
    .crc_valid  (crc_valid),
    .out_crc    (out_crc),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .err        (err),
    .busy       (busy)
  );

  int         total = 0;
  int         bad = 0;
  logic       exp_bits[$];
  logic [7:0] exp_crc[$];
  logic [7:0] eng_crc = 8'hA5;
  logic       eng_en = 1'b1;
  logic       prev_active = 1'b0;
  int         err_cnt = 0, out_cnt = 0, out_seen = 0, run_len = 0, last_run = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a byte until accepted; optionally queue its bits for the engine monitor.
  task automatic send_byte(input logic [7:0] d, input logic last, input logic track);
    logic ok;
    int   n;
    ok = 1'b0;
    n  = 0;
    in_data  = d;
    in_last  = last;
    in_valid = 1'b1;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("send_accepted", 32'(ok), 1);
    if (track) for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
  endtask

  task automatic wait_fall();
    int   n;
    logic rose;
    n = 0;
    rose = 1'b0;
    while (n < 200 && !(rose && !crc_active)) begin
      @(negedge clk);
      if (crc_active) rose = 1'b1;
      n++;
    end
    check("active_fall", 32'(rose && !crc_active), 1);
  endtask

  task automatic wait_out(input int target);
    int n;
    n = 0;
    while (out_cnt < target && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("out_count", out_cnt, target);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("busy_low", 32'(busy), 0);
  endtask

  task automatic check_reset_outputs();
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_crc_rst_n", 32'(crc_rst_n), 0);
    check("rst_crc_active", 32'(crc_active), 0);
    check("rst_crc_data", 32'(crc_data), 0);
    check("rst_out_crc", 32'(out_crc), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_err", 32'(err), 0);
    check("rst_busy", 32'(busy), 0);
  endtask

  // Engine model: VALID two cycles after ACTIVE falls, then eng_crc LSB-first.
  initial begin
    crc_valid = 1'b0;
    crc_bit   = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (prev_active && !crc_active && eng_en) begin
        step(2);
        crc_valid = 1'b1;
        step(1);
        crc_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
          crc_bit = eng_crc[i];
          step(1);
        end
        crc_bit = 1'b0;
      end
      prev_active = crc_active;
    end
  end

  // Monitor: engine bit stream, ACTIVE run length, ERR pulses and result handshakes.
  always @(negedge clk) begin
    if (!rst) begin
      if (crc_active) begin
        run_len++;
        check("bit_expected", 32'(exp_bits.size() != 0), 1);
        if (exp_bits.size() != 0) check("crc_data", 32'(crc_data), 32'(exp_bits.pop_front()));
      end else if (run_len != 0) begin
        last_run = run_len;
        run_len  = 0;
      end
      if (err) err_cnt++;
      if (out_valid) out_seen++;
      if (out_valid && out_ready) begin
        check("crc_expected", 32'(exp_crc.size() != 0), 1);
        if (exp_crc.size() != 0) check("out_crc", 32'(out_crc), 32'(exp_crc.pop_front()));
        out_cnt++;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, low, k, e0, o0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    step(2);
    check("idle_ready", 32'(in_ready), 1);
    check("idle_crc_rst_n", 32'(crc_rst_n), 1);

    // Single-byte frame.
    e0 = err_cnt;
    send_byte(8'hD8, 1'b1, 1'b1);
    exp_crc.push_back(eng_crc);
    n = 0;
    low = 0;
    while (!crc_active && n < 20) begin
      @(negedge clk);
      if (!crc_rst_n) low++;
      n++;
    end
    check("eng_rst_cycles", low, 1);
    wait_fall();
    @(negedge clk);
    check("run_1byte", last_run, 8);
    wait_out(1);
    wait_idle();
    check("err_1byte", err_cnt - e0, 0);
    step(4);

    // Three-byte frame, later bytes offered mid-shift.
    e0 = err_cnt;
    send_byte(8'h12, 1'b0, 1'b1);
    step(4);
    send_byte(8'h34, 1'b0, 1'b1);
    step(8);
    send_byte(8'h56, 1'b1, 1'b1);
    exp_crc.push_back(eng_crc);
    wait_fall();
    @(negedge clk);
    check("run_3byte", last_run, 24);
    wait_out(2);
    wait_idle();
    check("err_3byte", err_cnt - e0, 0);
    step(4);

    // Underrun: second byte withheld past the boundary.
    e0 = err_cnt;
    o0 = out_seen;
    send_byte(8'h81, 1'b0, 1'b1);
    wait_fall();
    @(negedge clk);
    check("run_underrun", last_run, 8);
    check("err_underrun", err_cnt - e0, 1);
    @(posedge clk);
    #1;
    send_byte(8'h22, 1'b0, 1'b0);
    send_byte(8'h33, 1'b1, 1'b0);
    wait_idle();
    step(20);
    check("err_underrun_once", err_cnt - e0, 1);
    check("no_out_underrun", out_seen - o0, 0);
    check("bits_drained", exp_bits.size(), 0);

    // Timeout: engine never answers.
    eng_en = 1'b0;
    e0 = err_cnt;
    o0 = out_seen;
    send_byte(8'h3C, 1'b1, 1'b1);
    wait_fall();
    k = 0;
    while (!err && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("timeout_cycles", k, 16);
    check("ready_after_timeout", 32'(in_ready), 1);
    @(negedge clk);
    check("err_timeout_once", err_cnt - e0, 1);
    check("busy_after_timeout", 32'(busy), 0);
    check("no_out_timeout", out_seen - o0, 0);
    @(posedge clk);
    #1;
    eng_en = 1'b1;
    step(4);

    // Output back-pressure with a competing input byte.
    out_ready = 1'b0;
    send_byte(8'h5A, 1'b1, 1'b1);
    exp_crc.push_back(eng_crc);
    n = 0;
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_rise", 32'(out_valid), 1);
    @(posedge clk);
    #1;
    in_data  = 8'hEE;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(out_valid), 1);
      check("stall_crc", 32'(out_crc), 32'(eng_crc));
      check("stall_ready", 32'(in_ready), 0);
    end
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    wait_out(3);
    @(negedge clk);
    check("out_valid_drop", 32'(out_valid), 0);
    step(4);

    // Reset while shifting.
    eng_en = 1'b0;
    e0 = err_cnt;
    send_byte(8'hF0, 1'b0, 1'b1);
    n = 0;
    while (!crc_active && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("active_before_reset", 32'(crc_active), 1);
    step(3);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_bits.delete();
    step(3);
    check("err_after_reset", err_cnt - e0, 0);
    check("ready_after_reset", 32'(in_ready), 1);
    eng_en = 1'b1;

    check("crc_queue_empty", exp_crc.size(), 0);
    check("bit_queue_empty", exp_bits.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/crc_serial_ctrl.md
Name: crc_serial_ctrl

Overview:
Sequencer that drives the bit-serial 8-bit CRC engine (ports RST active-low, ACTIVE, DATA, CRC, VALID) from a byte-wide stream.
- Accepts bytes over a valid/ready handshake, resets the engine per frame, and shifts each byte LSB-first with ACTIVE held continuously.
- Waits for engine VALID, deserialises the 8 CRC bits LSB-first, and presents the result on a valid/ready output.
- Sits between the packet datapath and the CRC engine; it is the engine's only driver.

Parameters:
DATA_WIDTH, 8, byte and CRC width
RST_CYCLES, 1, cycles CRC_RST_N held low at frame start
TIMEOUT_CYCLES, 16, max cycles waiting for CRC_VALID after ACTIVE falls

Ports:
CLK  in  1  clock
RST  in  1  synchronous, active-high reset
IN_DATA  in  DATA_WIDTH  frame byte
IN_VALID  in  1  byte valid
IN_LAST  in  1  byte is last of frame
IN_READY  out  1  byte accepted when IN_VALID&IN_READY
CRC_RST_N  out  1  to engine RST (active-low)
CRC_ACTIVE  out  1  to engine ACTIVE
CRC_DATA  out  1  to engine DATA
CRC_BIT  in  1  from engine CRC
CRC_VALID  in  1  from engine VALID
OUT_CRC  out  DATA_WIDTH  collected CRC
OUT_VALID  out  1  OUT_CRC valid
OUT_READY  in  1  consumer accepts OUT_CRC
ERR  out  1  one-cycle pulse: underrun or timeout
BUSY  out  1  high in any state except IDLE

Behaviour:
- All outputs registered. During RST and on the cycle after it: IN_READY=0, CRC_RST_N=0, CRC_ACTIVE=0, CRC_DATA=0, OUT_CRC=0, OUT_VALID=0, ERR=0, BUSY=0, state=IDLE. Reset mid-frame aborts silently with no ERR.
- IDLE: IN_READY=1, CRC_RST_N=1. On accept, load the byte into the shift register, record last, go to ENG_RST.
- ENG_RST: CRC_RST_N=0 for RST_CYCLES cycles, IN_READY=0, then go to SHIFT.
- SHIFT: CRC_ACTIVE=1, CRC_DATA=sr[0], shift right each cycle, bit counter 0..DATA_WIDTH-1.
  - 8 cycles per byte; bit 0 is driven on the first cycle.
  - A one-entry holding register accepts the next byte while shifting.
  - IN_READY = holding empty AND last not yet accepted.
- Byte boundary (counter=DATA_WIDTH-1):
  - If the current byte is last, go to WAIT_VALID.
  - Else if holding is full, or a byte is accepted this same cycle, move it into sr and continue SHIFT with no ACTIVE gap.
  - Else underrun: ERR pulse, CRC_ACTIVE=0, go to DRAIN.
- DRAIN: IN_READY=1; discard bytes up to and including IN_LAST, then go to IDLE. The engine result is ignored.
- WAIT_VALID: CRC_ACTIVE=0. Sampling CRC_VALID=1 goes to COLLECT. After TIMEOUT_CYCLES cycles without it: ERR pulse, go to IDLE.
- COLLECT: for DATA_WIDTH cycles, sample CRC_BIT into bit i on the i-th cycle (LSB first), then go to OUTPUT.
- OUTPUT: OUT_VALID=1 with OUT_CRC stable until OUT_READY. The cycle OUT_VALID&OUT_READY goes to IDLE, and OUT_VALID drops on the next cycle.
- Simultaneous events:
  - IN_VALID in OUTPUT is not accepted (IN_READY=0).
  - Timeout and CRC_VALID in the same cycle: CRC_VALID wins.
- Single-byte frame (IN_LAST on first byte): exactly 8 ACTIVE cycles.
- Minimum latency, accept to OUT_VALID: RST_CYCLES + 8*N + wait + DATA_WIDTH + 1.

Decomposition:
- Package crc_ctrl_pkg: state enum (IDLE, ENG_RST, SHIFT, DRAIN, WAIT_VALID, COLLECT, OUTPUT), DATA_WIDTH default, counter width constants.
- Sub-module crc_bit_serializer: shift register, holding register, bit counter, byte-boundary/underrun flags.
- The FSM, timeout counter and collector stay in the top.

Test Plan:
- Bench engine model: raises CRC_VALID 2 cycles after ACTIVE falls, then drives 8'hA5 on CRC_BIT LSB-first, starting the cycle after VALID rises.
- Single byte 8'hD8 with IN_LAST:
  - CRC_RST_N low 1 cycle, then CRC_DATA = 0,0,0,1,1,0,1,1 over exactly 8 ACTIVE cycles.
  - Then OUT_CRC=8'hA5 with OUT_VALID=1 and ERR never high.
- Three-byte frame 8'h12, 8'h34, 8'h56 (last), each presented mid-shift:
  - 24 contiguous ACTIVE cycles with no gap.
  - Then OUT_CRC=8'hA5.
- Second byte withheld past the byte boundary: ERR pulses once, ACTIVE drops after 8 cycles; later bytes up to IN_LAST are consumed; BUSY falls; no OUT_VALID.
- Engine model never raises VALID: ERR pulses exactly 16 cycles after ACTIVE falls, then the controller returns to IDLE with IN_READY=1.
- OUT_READY held low for 5 cycles:
  - OUT_VALID and OUT_CRC=8'hA5 stay stable; IN_READY=0 throughout.
  - RST asserted in SHIFT: next cycle all outputs are at reset values, with no ERR.
